// File: rtl/foc_cmd_scheduler.sv
// FOC command sequencer: decodes SPI opcodes, gathers 5-word bursts, commits gains/samples, launches the FOC core.
// Latency: last data pop -> foc_valid 1 cycle; pops only from non-empty FIFOs; every wait is bounded by TIMEOUT.
module foc_cmd_scheduler #(
  parameter int D_WIDTH = 16,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic                      clk_sys,
  input  logic                      rstb,
  input  logic                      empty_opcode,
  input  logic [7:0]                fifo_opcode,
  output logic                      rd_en_opcode,
  input  logic                      empty_data,
  input  logic [D_WIDTH-1:0]        fifo_data,
  output logic                      rd_en_data,
  output logic signed [D_WIDTH-1:0] kpd,
  output logic signed [D_WIDTH-1:0] kid,
  output logic signed [D_WIDTH-1:0] kpq,
  output logic signed [D_WIDTH-1:0] kiq,
  output logic [D_WIDTH-1:0]        period_top,
  output logic signed [D_WIDTH-1:0] curr_a,
  output logic signed [D_WIDTH-1:0] curr_b,
  output logic signed [D_WIDTH-1:0] curr_c,
  output logic signed [D_WIDTH-1:0] curr_t,
  output logic [D_WIDTH-1:0]        angle,
  output logic                      foc_valid,
  input  logic                      foc_ready,
  output logic                      host_ready,
  output logic [15:0]               sample_cnt,
  output logic [2:0]                err_flags
);

  typedef enum logic [2:0] {
    IDLE,
    CFG_COLLECT,
    CFG_COMMIT,
    SMP_COLLECT,
    SMP_ISSUE,
    SMP_BLANK,
    SMP_WAIT
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [2:0]         word_idx;
  logic [D_WIDTH-1:0] stage [0:4];

  logic timed_out, last_word;
  logic cfg_load, smp_load, smp_done;
  logic host_hold, host_rel;
  logic set_bad, set_und, set_foc, clr_err;

  assign timed_out    = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign last_word    = (word_idx == 3'd4);
  // Gated by rstb so no FIFO entry is lost while the block is held in reset.
  assign rd_en_opcode = rstb && (state == IDLE) && !empty_opcode;
  assign rd_en_data   = rstb && ((state == CFG_COLLECT) || (state == SMP_COLLECT)) && !empty_data;
  assign foc_valid    = (state == SMP_ISSUE);

  always_comb begin
    state_nxt = state;
    cfg_load  = 1'b0;
    smp_load  = 1'b0;
    smp_done  = 1'b0;
    host_hold = 1'b0;
    host_rel  = 1'b0;
    set_bad   = 1'b0;
    set_und   = 1'b0;
    set_foc   = 1'b0;
    clr_err   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_en_opcode) begin
          case (fifo_opcode)
            8'h00: state_nxt = CFG_COLLECT;
            8'hFF: begin
              state_nxt = SMP_COLLECT;
              host_hold = 1'b1;
            end
            8'h01:   clr_err = 1'b1;
            default: set_bad = 1'b1;
          endcase
        end
      end
      CFG_COLLECT, SMP_COLLECT: begin
        if (rd_en_data) begin
          if (last_word) begin
            state_nxt = (state == CFG_COLLECT) ? CFG_COMMIT : SMP_ISSUE;
            smp_load  = (state == SMP_COLLECT);
          end
        end else if (timed_out) begin
          set_und   = 1'b1;
          host_rel  = 1'b1;
          state_nxt = IDLE;
        end
      end
      CFG_COMMIT: begin
        cfg_load  = 1'b1;
        state_nxt = IDLE;
      end
      SMP_ISSUE: begin
        if (foc_ready) begin
          state_nxt = SMP_BLANK;
        end else if (timed_out) begin
          set_foc   = 1'b1;
          host_rel  = 1'b1;
          state_nxt = IDLE;
        end
      end
      // The core needs one cycle to drop foc_ready after accepting a launch.
      SMP_BLANK: state_nxt = SMP_WAIT;
      SMP_WAIT: begin
        if (foc_ready) begin
          smp_done  = 1'b1;
          host_rel  = 1'b1;
          state_nxt = IDLE;
        end else if (timed_out) begin
          set_foc   = 1'b1;
          host_rel  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      word_idx <= '0;
      for (int i = 0; i < 5; i++) stage[i] <= '0;
    end else begin
      state <= state_nxt;
      // Timeout window restarts on each popped word and on every state change.
      if ((state_nxt != state) || rd_en_data)
        tmo_cnt <= '0;
      else if ((state != IDLE) && (state != CFG_COMMIT) && (state != SMP_BLANK))
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (state_nxt != state)
        word_idx <= '0;
      else if (rd_en_data)
        word_idx <= word_idx + 3'd1;
      if (rd_en_data)
        stage[word_idx] <= fifo_data;
    end
  end

  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      kpd        <= '0;
      kid        <= '0;
      kpq        <= '0;
      kiq        <= '0;
      period_top <= '0;
      curr_a     <= '0;
      curr_b     <= '0;
      curr_c     <= '0;
      curr_t     <= '0;
      angle      <= '0;
      host_ready <= 1'b1;
      sample_cnt <= '0;
      err_flags  <= '0;
    end else begin
      if (cfg_load) begin
        kpd        <= stage[0];
        kid        <= stage[1];
        kpq        <= stage[2];
        kiq        <= stage[3];
        period_top <= stage[4];
      end
      // The fifth sample word bypasses staging so foc_valid rises one cycle after its pop.
      if (smp_load) begin
        curr_a <= stage[0];
        curr_b <= stage[1];
        curr_c <= stage[2];
        curr_t <= stage[3];
        angle  <= fifo_data;
      end
      if (host_hold)
        host_ready <= 1'b0;
      else if (host_rel)
        host_ready <= 1'b1;
      if (smp_done)
        sample_cnt <= sample_cnt + 16'd1;
      err_flags <= (clr_err ? 3'b000 : err_flags) | {set_foc, set_und, set_bad};
    end
  end

endmodule

// File: tb/tb_foc_cmd_scheduler.sv
// Scoreboard bench for foc_cmd_scheduler: command-level model feeds expectation queues, a negedge monitor checks.
module tb_foc_cmd_scheduler;
  localparam int DW  = 16;
  localparam int TMO = 16;
  localparam int CW  = 5;

  typedef struct packed {
    logic [79:0] v;
    logic [31:0] dur;
  } launch_t;

  logic          clk_sys = 1'b0;
  logic          rstb = 1'b1;
  logic          empty_opcode = 1'b1;
  logic [7:0]    fifo_opcode = 8'h00;
  logic          rd_en_opcode;
  logic          empty_data = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          rd_en_data;
  logic [DW-1:0] kpd, kid, kpq, kiq, period_top;
  logic [DW-1:0] curr_a, curr_b, curr_c, curr_t, angle;
  logic          foc_valid;
  logic          foc_ready = 1'b1;
  logic          host_ready;
  logic [15:0]   sample_cnt;
  logic [2:0]    err_flags;

  always #5 clk_sys = ~clk_sys;

  foc_cmd_scheduler #(.D_WIDTH(DW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_sys(clk_sys), .rstb(rstb),
    .empty_opcode(empty_opcode), .fifo_opcode(fifo_opcode), .rd_en_opcode(rd_en_opcode),
    .empty_data(empty_data), .fifo_data(fifo_data), .rd_en_data(rd_en_data),
    .kpd(kpd), .kid(kid), .kpq(kpq), .kiq(kiq), .period_top(period_top),
    .curr_a(curr_a), .curr_b(curr_b), .curr_c(curr_c), .curr_t(curr_t), .angle(angle),
    .foc_valid(foc_valid), .foc_ready(foc_ready), .host_ready(host_ready),
    .sample_cnt(sample_cnt), .err_flags(err_flags)
  );

  // FIFO contents, expectation queues and the command-level model state.
  bit [7:0]    op_q[$];
  bit [15:0]   dat_q[$];
  logic [79:0] cfg_q[$];
  launch_t     launch_q[$];
  logic [79:0] exp_cfg = '0, exp_smp = '0;
  logic [2:0]  exp_err = '0;
  logic [15:0] exp_cnt = '0;

  int cyc = 0, last_pop = -100, busy = 0;
  bit hang = 1'b0;
  int tests = 0, fails = 0;
  int req_id = 0, done_id = 0, drv_err = 0;

  logic [79:0] cur_cfg, cur_smp;
  assign cur_cfg = {kpd, kid, kpq, kiq, period_top};
  assign cur_smp = {curr_a, curr_b, curr_c, curr_t, angle};

  // Show-ahead FIFO and FOC core model.
  always @(posedge clk_sys) begin
    bit po, pd, xfer;
    cyc++;
    po   = rd_en_opcode;
    pd   = rd_en_data;
    xfer = foc_valid && foc_ready;
    if (pd) last_pop = cyc;
    #1;
    if (po && op_q.size() > 0) void'(op_q.pop_front());
    if (pd && dat_q.size() > 0) void'(dat_q.pop_front());
    if (xfer) busy = $urandom_range(0, 6);
    else if (busy > 0) busy--;
    empty_opcode = (op_q.size() == 0);
    fifo_opcode  = empty_opcode ? 8'h00 : op_q[0];
    empty_data   = (dat_q.size() == 0);
    fifo_data    = empty_data ? 16'h0000 : dat_q[0];
    foc_ready    = !hang && (busy == 0);
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every output event is matched against the scoreboard.
  bit          vld_prev = 1'b0;
  int          vld_len = 0;
  logic [31:0] exp_len = '0;
  logic [79:0] prev_cfg = '0;
  logic [2:0]  err_prev = '0;

  always @(negedge clk_sys) begin
    launch_t lr;
    if (!rstb) begin
      chk("rd_en_in_reset", {78'd0, rd_en_opcode, rd_en_data}, 80'd0);
      vld_prev = 1'b0;
    end else begin
      if (cur_cfg !== prev_cfg) begin
        if (cfg_q.size() == 0) chk("cfg_unexpected_update", cur_cfg, prev_cfg);
        else chk("cfg_commit", cur_cfg, cfg_q.pop_front());
      end
      if (foc_valid && !vld_prev) begin
        if (launch_q.size() == 0) begin
          chk("launch_unexpected", {79'd0, foc_valid}, 80'd0);
          exp_len = 0;
        end else begin
          lr = launch_q.pop_front();
          chk("launch_samples", cur_smp, lr.v);
          chk("launch_latency", 80'(cyc - last_pop), 80'd0);
          chk("host_ready_busy", {79'd0, host_ready}, 80'd0);
          exp_len = lr.dur;
        end
        vld_len = 1;
      end else if (foc_valid) begin
        vld_len++;
      end
      if (!foc_valid && vld_prev) chk("valid_duration", 80'(vld_len), 80'(exp_len));
      if (err_flags[1] && !err_prev[1]) chk("underrun_delay", 80'(cyc - last_pop), 80'(TMO));
      vld_prev = foc_valid;
    end
    prev_cfg = cur_cfg;
    err_prev = err_flags;
    if (done_id != req_id) begin
      chk("cfg_regs", cur_cfg, exp_cfg);
      chk("smp_regs", cur_smp, exp_smp);
      chk("err_flags", {77'd0, err_flags}, {77'd0, exp_err});
      chk("sample_cnt", {64'd0, sample_cnt}, {64'd0, exp_cnt});
      chk("host_ready_idle", {79'd0, host_ready}, 80'd1);
      chk("foc_valid_idle", {79'd0, foc_valid}, 80'd0);
      chk("cfg_q_left", 80'(cfg_q.size()), 80'd0);
      chk("launch_q_left", 80'(launch_q.size()), 80'd0);
      chk("drv_timeouts", 80'(drv_err), 80'd0);
      done_id = req_id;
    end
  end

  // Command-level reference: what each opcode plus its burst should do.
  task automatic model(input logic [7:0] op, input int n, input logic [79:0] w, input bit hung);
    launch_t r;
    case (op)
      8'h00: begin
        if (n == 5) begin
          cfg_q.push_back(w);
          exp_cfg = w;
        end else exp_err[1] = 1'b1;
      end
      8'hFF: begin
        if (n == 5) begin
          r.v   = w;
          r.dur = hung ? TMO : 1;
          launch_q.push_back(r);
          exp_smp = w;
          if (hung) exp_err[2] = 1'b1;
          else exp_cnt = exp_cnt + 16'd1;
        end else exp_err[1] = 1'b1;
      end
      8'h01:   exp_err = 3'b000;
      default: exp_err[0] = 1'b1;
    endcase
  endtask

  task automatic send(input logic [7:0] op, input int n, input logic [79:0] w);
    @(negedge clk_sys);
    op_q.push_back(op);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_sys);
      dat_q.push_back(w[79-16*i -: 16]);
    end
  endtask

  task automatic cmd(input logic [7:0] op, input int n, input logic [79:0] w, input bit hung);
    model(op, n, w, hung);
    send(op, n, w);
  endtask

  task automatic request_check();
    int k;
    req_id++;
    for (k = 0; k < 20 && done_id != req_id; k++) @(negedge clk_sys);
    if (done_id != req_id) begin
      drv_err++;
      $display("FAIL check_handshake: got done %0d expected %0d", done_id, req_id);
    end
  endtask

  task automatic settle();
    int k;
    for (k = 0; k < 3000 && (op_q.size() != 0 || dat_q.size() != 0); k++) @(negedge clk_sys);
    if (k == 3000) drv_err++;
    repeat (2 * TMO + 8) @(negedge clk_sys);
    request_check();
  endtask

  function automatic logic [79:0] rand_words();
    return {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  initial begin
    int k;
    logic [79:0] w;
    int r;
    #2 rstb = 1'b0;
    repeat (3) @(negedge clk_sys);
    request_check();
    @(posedge clk_sys); #2 rstb = 1'b1;

    cmd(8'h00, 5, {16'h0100, 16'h0020, 16'h0200, 16'h0040, 16'h03E8}, 1'b0);
    settle();
    cmd(8'hFF, 5, {16'h0010, 16'hFFF0, 16'h0000, 16'h0050, 16'h1234}, 1'b0);
    settle();

    cmd(8'hFF, 3, rand_words(), 1'b0);
    settle();
    cmd(8'h01, 0, '0, 1'b0);
    settle();

    hang = 1'b1;
    cmd(8'hFF, 5, rand_words(), 1'b1);
    settle();
    hang = 1'b0;

    cmd(8'h55, 0, '0, 1'b0);
    cmd(8'h00, 5, rand_words(), 1'b0);
    settle();

    // Reset in the middle of a config burst with both FIFOs holding entries.
    send(8'h00, 2, rand_words());
    for (k = 0; k < 200 && dat_q.size() != 0; k++) @(negedge clk_sys);
    if (k == 200) drv_err++;
    repeat (2) @(negedge clk_sys);
    op_q.push_back(8'h55);
    @(posedge clk_sys); #2 rstb = 1'b0;
    dat_q.push_back(16'h1111);
    exp_cfg = '0;
    exp_smp = '0;
    exp_err = '0;
    exp_cnt = '0;
    repeat (3) @(negedge clk_sys);
    request_check();
    op_q.delete();
    dat_q.delete();
    repeat (2) @(negedge clk_sys);
    @(posedge clk_sys); #2 rstb = 1'b1;
    cmd(8'h00, 5, rand_words(), 1'b0);
    settle();

    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 5; j++) begin
        r = $urandom_range(0, 9);
        w = rand_words();
        if (r < 4) cmd(8'h00, 5, w, 1'b0);
        else if (r < 8) cmd(8'hFF, 5, w, 1'b0);
        else if (r == 8) cmd(8'($urandom_range(2, 254)), 0, w, 1'b0);
        else cmd(8'h01, 0, w, 1'b0);
      end
      settle();
    end

    request_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
